branch_resolve_unit: RTL and testbench

- Consumer end of the BRU writeback interface. Captures BRU results (taken/predict-ok, JIRL flag, real target) in a ROB-tag-indexed table.
- At commit of a branch at ROB head, compares the captured result against the front-end prediction.
- On mispredict, drives redirect plus the back-end flush (flush_back) and sends one predictor-update beat per committed branch.
- Sits between the BRU output register, the ROB commit port and the front-end BPU.

---
 rtl/branch_resolve_unit_pkg.sv | 20 ++
 rtl/br_res_table.sv | 41 ++++
 rtl/branch_resolve_unit.sv | 122 ++++++++++++
 tb/tb_branch_resolve_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: table entry payload, FSM states, PC step.
package branch_resolve_unit_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned PC_STEP = 4;
  localparam int unsigned CNT_W   = 4;

  typedef struct packed {
    logic            valid;
    logic            taken;
    logic            isjirl;
    logic [XLEN-1:0] target;
  } br_res_t;

  typedef enum logic {
    RES_IDLE,
    RES_FLUSH
  } res_state_e;

endpackage

// File: rtl/br_res_table.sv
// ROB-tag-indexed store of BRU results with same-tag write bypass on the read port,
// per-entry invalidate on commit and a global clear on flush.
module br_res_table
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [TAG_W-1:0] wr_tag,
  input  br_res_t          wr_data,
  input  logic             inv_en,
  input  logic [TAG_W-1:0] inv_tag,
  input  logic             clr,
  input  logic [TAG_W-1:0] rd_tag,
  output br_res_t          rd_data_c
);

  localparam int unsigned DEPTH = 2 ** TAG_W;

  br_res_t mem_q [DEPTH];

  // Clear beats everything; an invalidate beats a write to the same tag since the result is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i].valid <= 1'b0;
    end else begin
      if (wr_en)  mem_q[wr_tag] <= wr_data;
      if (inv_en) mem_q[inv_tag].valid <= 1'b0;
    end
  end

  always_comb begin
    rd_data_c = mem_q[rd_tag];
    if (wr_en && (wr_tag == rd_tag)) rd_data_c = wr_data;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves committed branches against captured BRU results; raises redirect, back-end
// flush and a predictor-update beat per committed branch.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned TAG_W        = 6,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bru_ready,
  input  logic [TAG_W-1:0] bru_tag_rob,
  input  logic             bru_branch,
  input  logic             bru_isjirl,
  input  logic [31:0]      bru_target_real,
  input  logic             commit_valid,
  input  logic [TAG_W-1:0] commit_tag,
  input  logic             commit_is_br,
  input  logic [31:0]      commit_pc,
  input  logic [31:0]      commit_offs,
  input  logic             commit_pred_taken,
  output logic             commit_ack,
  output logic             flush_back,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             bpu_upd_valid,
  output logic [31:0]      bpu_upd_pc,
  output logic             bpu_upd_taken,
  output logic [31:0]      bpu_upd_target
);

  res_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;

  br_res_t     wr_data;
  br_res_t     rd_data;
  logic        wr_en;
  logic        resolve;
  logic        mispred;
  logic        act_taken;
  logic [31:0] act_target;
  logic [31:0] tgt_taken;
  logic [31:0] tgt_seq;

  br_res_table #(
    .TAG_W (TAG_W)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_tag    (bru_tag_rob),
    .wr_data   (wr_data),
    .inv_en    (resolve),
    .inv_tag   (commit_tag),
    .clr       (mispred),
    .rd_tag    (commit_tag),
    .rd_data_c (rd_data)
  );

  // Lookup and compare; writes are dropped outside IDLE because the BRU is being flushed too.
  always_comb begin
    wr_data    = '{valid: 1'b1, taken: bru_branch, isjirl: bru_isjirl, target: bru_target_real};
    wr_en      = bru_ready && (state_q == RES_IDLE);
    tgt_taken  = commit_pc + commit_offs;
    tgt_seq    = commit_pc + 32'(PC_STEP);
    commit_ack = !rst && (state_q == RES_IDLE) && commit_valid &&
                 (!commit_is_br || rd_data.valid);
    resolve    = commit_ack && commit_is_br;
    act_taken  = rd_data.taken;
    act_target = rd_data.taken ? tgt_taken : tgt_seq;
    mispred    = resolve && (rd_data.taken != commit_pred_taken);
    if (rd_data.isjirl) begin
      act_taken  = 1'b1;
      act_target = rd_data.target;
      mispred    = resolve && !rd_data.taken;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RES_IDLE;
      cnt_q          <= '0;
      flush_back     <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      bpu_upd_valid  <= 1'b0;
      bpu_upd_pc     <= '0;
      bpu_upd_taken  <= 1'b0;
      bpu_upd_target <= '0;
    end else begin
      redirect_valid <= 1'b0;
      bpu_upd_valid  <= 1'b0;
      case (state_q)
        RES_IDLE: begin
          if (resolve) begin
            bpu_upd_valid  <= 1'b1;
            bpu_upd_pc     <= commit_pc;
            bpu_upd_taken  <= act_taken;
            bpu_upd_target <= act_target;
          end
          if (mispred) begin
            redirect_valid <= 1'b1;
            redirect_pc    <= act_target;
            flush_back     <= 1'b1;
            state_q        <= RES_FLUSH;
            cnt_q          <= CNT_W'(FLUSH_CYCLES - 1);
          end
        end
        RES_FLUSH: begin
          if (cnt_q == '0) begin
            state_q    <= RES_IDLE;
            flush_back <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= RES_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized and directed bench for branch_resolve_unit against a behavioural model.
module tb_branch_resolve_unit;

  localparam int TAG_W = 6;
  localparam int DEPTH = 64;
  localparam int FC    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             bru_ready;
  logic [TAG_W-1:0] bru_tag_rob;
  logic             bru_branch;
  logic             bru_isjirl;
  logic [31:0]      bru_target_real;
  logic             commit_valid;
  logic [TAG_W-1:0] commit_tag;
  logic             commit_is_br;
  logic [31:0]      commit_pc;
  logic [31:0]      commit_offs;
  logic             commit_pred_taken;
  logic             commit_ack;
  logic             flush_back;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             bpu_upd_valid;
  logic [31:0]      bpu_upd_pc;
  logic             bpu_upd_taken;
  logic [31:0]      bpu_upd_target;

  branch_resolve_unit #(
    .TAG_W        (TAG_W),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .bru_ready         (bru_ready),
    .bru_tag_rob       (bru_tag_rob),
    .bru_branch        (bru_branch),
    .bru_isjirl        (bru_isjirl),
    .bru_target_real   (bru_target_real),
    .commit_valid      (commit_valid),
    .commit_tag        (commit_tag),
    .commit_is_br      (commit_is_br),
    .commit_pc         (commit_pc),
    .commit_offs       (commit_offs),
    .commit_pred_taken (commit_pred_taken),
    .commit_ack        (commit_ack),
    .flush_back        (flush_back),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .bpu_upd_valid     (bpu_upd_valid),
    .bpu_upd_pc        (bpu_upd_pc),
    .bpu_upd_taken     (bpu_upd_taken),
    .bpu_upd_target    (bpu_upd_target)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: resolved-result table plus remaining flush cycles.
  bit          m_valid [DEPTH];
  bit          m_taken [DEPTH];
  bit          m_jirl  [DEPTH];
  logic [31:0] m_tgt   [DEPTH];
  int          flush_left;
  bit          exp_rv, exp_uv, exp_ut;
  logic [31:0] exp_rpc, exp_upc, exp_utgt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    flush_left = 0;
  endtask

  task automatic set_bru(input bit rdy, input int tag, input bit br, input bit jr,
                         input logic [31:0] tgt);
    bru_ready = rdy; bru_tag_rob = TAG_W'(tag); bru_branch = br;
    bru_isjirl = jr; bru_target_real = tgt;
  endtask

  task automatic set_commit(input bit v, input int tag, input bit br, input logic [31:0] pc,
                            input logic [31:0] offs, input bit pred);
    commit_valid = v; commit_tag = TAG_W'(tag); commit_is_br = br;
    commit_pc = pc; commit_offs = offs; commit_pred_taken = pred;
  endtask

  task automatic idle_inputs();
    set_bru(0, 0, 0, 0, 32'h0);
    set_commit(0, 0, 0, 32'h0, 32'h0, 0);
  endtask

  // One clock: check combinational ack, advance the model, check registered outputs.
  task automatic step();
    bit idle, byp, hit, ack, mis, tk, jr;
    logic [31:0] tg, at;
    #1;
    idle = (flush_left == 0);
    byp  = idle && bru_ready && (bru_tag_rob == commit_tag);
    hit  = byp || m_valid[commit_tag];
    ack  = idle && commit_valid && (!commit_is_br || hit);
    check("commit_ack", 32'(commit_ack), 32'(ack));
    if (byp) begin
      tk = bru_branch; jr = bru_isjirl; tg = bru_target_real;
    end else begin
      tk = m_taken[commit_tag]; jr = m_jirl[commit_tag]; tg = m_tgt[commit_tag];
    end
    exp_rv = 0; exp_uv = 0; mis = 0;
    if (ack && commit_is_br) begin
      exp_uv  = 1;
      exp_upc = commit_pc;
      if (jr) begin
        exp_ut = 1; at = tg; mis = !tk;
      end else begin
        exp_ut = tk;
        at = tk ? commit_pc + commit_offs : commit_pc + 32'd4;
        mis = (tk != commit_pred_taken);
      end
      exp_utgt = at;
      if (mis) begin exp_rv = 1; exp_rpc = at; end
    end
    if (flush_left > 0) flush_left--;
    else if (mis) begin
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      flush_left = FC;
    end else begin
      if (bru_ready) begin
        m_valid[bru_tag_rob] = 1'b1; m_taken[bru_tag_rob] = bru_branch;
        m_jirl[bru_tag_rob]  = bru_isjirl; m_tgt[bru_tag_rob] = bru_target_real;
      end
      if (ack && commit_is_br) m_valid[commit_tag] = 1'b0;
    end
    @(posedge clk);
    #1;
    check("flush_back", 32'(flush_back), 32'(flush_left > 0));
    check("redirect_valid", 32'(redirect_valid), 32'(exp_rv));
    if (exp_rv) check("redirect_pc", redirect_pc, exp_rpc);
    check("bpu_upd_valid", 32'(bpu_upd_valid), 32'(exp_uv));
    if (exp_uv) begin
      check("bpu_upd_pc", bpu_upd_pc, exp_upc);
      check("bpu_upd_taken", 32'(bpu_upd_taken), 32'(exp_ut));
      check("bpu_upd_target", bpu_upd_target, exp_utgt);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    set_commit(1, 0, 0, 32'h0, 32'h0, 0);
    #1;
    check("rst_ack", 32'(commit_ack), 32'h0);
    check("rst_flush", 32'(flush_back), 32'h0);
    check("rst_redirect", 32'(redirect_valid), 32'h0);
    check("rst_upd", 32'(bpu_upd_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    step();

    // Correctly predicted taken branch.
    set_bru(1, 3, 1, 0, 32'h0);
    step();
    idle_inputs();
    step();
    set_commit(1, 3, 1, 32'h1C00_0100, 32'h20, 1);
    step();
    check("tk_upd_valid", 32'(bpu_upd_valid), 32'h1);
    check("tk_upd_target", bpu_upd_target, 32'h1C00_0120);
    check("tk_no_redirect", 32'(redirect_valid), 32'h0);

    // Not-taken mispredict; tag 7 written beforehand must be gone after the flush.
    idle_inputs();
    set_bru(1, 7, 1, 0, 32'h0);
    step();
    set_bru(1, 2, 0, 0, 32'h0);
    step();
    idle_inputs();
    set_commit(1, 2, 1, 32'h1C00_0200, 32'h40, 1);
    step();
    check("mp_redirect_pc", redirect_pc, 32'h1C00_0204);
    check("mp_flush", 32'(flush_back), 32'h1);
    set_commit(1, 0, 0, 32'h0, 32'h0, 0);
    set_bru(1, 8, 1, 0, 32'h0);
    for (int i = 0; i < FC; i++) step();
    check("mp_flush_done", 32'(flush_back), 32'h0);
    idle_inputs();
    set_commit(1, 7, 1, 32'h1C00_0300, 32'h10, 1);
    #1;
    check("table_empty", 32'(commit_ack), 32'h0);
    step();

    // JIRL with wrong predicted target.
    idle_inputs();
    set_bru(1, 4, 0, 1, 32'h1C00_8000);
    step();
    idle_inputs();
    set_commit(1, 4, 1, 32'h1C00_0400, 32'h0, 0);
    step();
    check("jirl_redirect_pc", redirect_pc, 32'h1C00_8000);
    check("jirl_upd_taken", 32'(bpu_upd_taken), 32'h1);
    idle_inputs();
    for (int i = 0; i < FC; i++) step();

    // Same-cycle bypass.
    set_bru(1, 9, 1, 0, 32'h0);
    set_commit(1, 9, 1, 32'h1C00_0500, 32'h8, 1);
    #1;
    check("bypass_ack", 32'(commit_ack), 32'h1);
    step();

    // Stall then resolve, with PC wrap on the fall-through target.
    idle_inputs();
    set_commit(1, 12, 1, 32'hFFFF_FFFC, 32'h100, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("stall_ack", 32'(commit_ack), 32'h0);
      step();
    end
    set_bru(1, 12, 0, 0, 32'h0);
    #1;
    check("resolve_ack", 32'(commit_ack), 32'h1);
    step();
    check("wrap_target", bpu_upd_target, 32'h0000_0000);

    // Reset in the middle of a flush.
    idle_inputs();
    set_bru(1, 1, 1, 0, 32'h0);
    step();
    idle_inputs();
    set_commit(1, 1, 1, 32'h1C00_0600, 32'h30, 0);
    step();
    idle_inputs();
    step();
    rst = 1'b1;
    set_commit(1, 0, 0, 32'h0, 32'h0, 0);
    #1;
    check("midrst_flush", 32'(flush_back), 32'h0);
    check("midrst_redirect", 32'(redirect_valid), 32'h0);
    check("midrst_ack", 32'(commit_ack), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    set_commit(1, 5, 1, 32'h1C00_0700, 32'h4, 0);
    #1;
    check("post_rst_stall", 32'(commit_ack), 32'h0);
    step();

    // Random traffic on a narrow tag range to force hits, bypasses and stalls.
    for (int n = 0; n < 600; n++) begin
      set_bru($urandom_range(0, 1) == 1, int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
              $urandom_range(0, 3) == 0, {$urandom(), 2'b00} );
      set_commit($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
                 $urandom_range(0, 9) < 7, {$urandom(), 2'b00},
                 32'($signed($urandom_range(0, 2047)) - 1024) << 2,
                 $urandom_range(0, 1) == 1);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
